// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = m-n-bin (mode 0) or |m-n-bin| (mode 1).
// Ports: clk, rst (async high), start/m/n/bin/mode in; busy, done, d, bout out.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] n,
  input  logic             bin,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int S  = WIDTH / DIGIT;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
    $error("serial_subtractor: bad WIDTH/DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_NEG,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] w;
  logic             mode_r;
  logic             brw;
  logic             pb;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       ca;
  logic [DIGIT-1:0]       cb;
  logic [DIGIT-1:0]       cd;
  logic                   co;
  logic [WIDTH+DIGIT-1:0] wt;
  logic [WIDTH-1:0]       wn;

  // Ripple of full subtractors over one digit.
  function automatic logic [DIGIT:0] fsub(
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             c
  );
    logic [DIGIT-1:0] r;
    logic             k;
    r = '0;
    k = c;
    for (int i = 0; i < DIGIT; i++) begin
      r[i] = a[i] ^ b[i] ^ k;
      k = (!a[i] & b[i]) | (!a[i] & k) | (b[i] & k);
    end
    return {k, r};
  endfunction

  // Operands shift right one digit per cycle so the current chunk is
  // always at the bottom; results enter w from the top, so after S
  // cycles w holds the whole word in place. NEG reuses w the same way.
  always_comb begin
    ca = '0;
    cb = '0;
    unique case (1'b1)
      (state == S_NEG): begin
        ca = '0;
        cb = w[DIGIT-1:0];
      end
      default: begin
        ca = a_r[DIGIT-1:0];
        cb = b_r[DIGIT-1:0];
      end
    endcase
    {co, cd} = fsub(ca, cb, brw);
    wt = {cd, w};
    wn = wt[WIDTH+DIGIT-1:DIGIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      w      <= '0;
      mode_r <= 1'b0;
      brw    <= 1'b0;
      pb     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_r    <= m;
            b_r    <= n;
            brw    <= bin;
            mode_r <= mode;
            w      <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_SUB;
          end
        end
        S_SUB: begin
          a_r <= a_r >> DIGIT;
          b_r <= b_r >> DIGIT;
          w   <= wn;
          brw <= co;
          if (cnt == LAST) begin
            cnt <= '0;
            pb  <= co;
            if (mode_r && co) begin
              brw   <= 1'b0;
              state <= S_NEG;
            end else begin
              d     <= wn;
              bout  <= co;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NEG: begin
          w   <= wn;
          brw <= co;
          if (cnt == LAST) begin
            cnt   <= '0;
            d     <= wn;
            bout  <= pb;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor with a result scoreboard.
// WIDTH=8, DIGIT=2.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] m;
  logic [7:0] n;
  logic       bin;
  logic       mode;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       b;
    int         lat;
  } exp_t;

  exp_t sbq[$];

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .m(m),
    .n(n),
    .bin(bin),
    .mode(mode),
    .busy(busy),
    .done(done),
    .d(d),
    .bout(bout)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [7:0] mm,
    input logic [7:0] nn,
    input logic       bb,
    input logic       md
  );
    exp_t e;
    logic [8:0] df;
    logic [8:0] mag;
    df = {1'b0, mm} - {1'b0, nn} - {8'd0, bb};
    e.b = df[8];
    mag = {1'b0, nn} + {8'd0, bb} - {1'b0, mm};
    e.d = (md && e.b) ? mag[7:0] : df[7:0];
    e.lat = (md && e.b) ? 8 : 4;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [7:0] mm, input logic [7:0] nn,
                        input logic bb, input logic md,
                        input bit harass);
    exp_t e;
    int   lat;
    int   extra;
    bit   got;
    @(negedge clk);
    m = mm;
    n = nn;
    bin = bb;
    mode = md;
    start = 1'b1;
    sbq.push_back(model(mm, nn, bb, md));
    @(posedge clk);
    #1;
    start = 1'b0;
    if (harass) begin
      start = 1'b1;
      m = ~mm;
      n = mm ^ nn ^ 8'h5a;
      bin = ~bb;
      mode = ~md;
    end
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (harass && k == 3) start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    e = sbq.pop_front();
    if (got) begin
      chk("d", 32'(d), 32'(e.d));
      chk("bout", 32'(bout), 32'(e.b));
      chk("latency", lat, e.lat);
      chk("busy_in_done", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk("done_width", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("d_hold", 32'(d), 32'(e.d));
    end
    if (harass) begin
      extra = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      chk("extra_done", extra, 0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("d_kept", 32'(d), 32'(e.d));
    end
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start = 1'b0;
    m = 8'h00;
    n = 8'h00;
    bin = 1'b0;
    mode = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 8'h7f, 1'b1, 1'b0, 1'b0);
    run_op(8'h00, 8'hff, 1'b1, 1'b1, 1'b0);
    run_op(8'hff, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(8'h3c, 8'h3c, 1'b1, 1'b1, 1'b0);
    run_op(8'h21, 8'h9e, 1'b0, 1'b0, 1'b1);
    run_op(8'h21, 8'h9e, 1'b1, 1'b1, 1'b1);

    // Abort mid-SUB with a one-cycle reset.
    @(negedge clk);
    m = 8'h33;
    n = 8'h11;
    bin = 1'b0;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom),
             1'($urandom), 1'b0);
    end

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
